// File: rtl/vga_pattern_pkg.sv
// Shared types and default 640x480@60 timing for the VGA test-pattern generator.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SCROLL = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_GRAD   = 2'd3
    } mode_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Total clocks per line, or total lines per frame.
    function automatic int unsigned timing_total(input int unsigned active, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..total-1.
    function automatic int unsigned count_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Control inputs and video outputs of the pattern generator; master = generator, slave = sink.
interface vga_pattern_gen_if #(
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned FRAME_BITS = 10
);
    logic [1:0]            mode_i;
    logic [2:0]            speed_i;
    logic                  pause_i;
    logic                  hsync_o;
    logic                  vsync_o;
    logic                  de_o;
    logic [COLOR_BITS-1:0] r_o;
    logic [COLOR_BITS-1:0] g_o;
    logic [COLOR_BITS-1:0] b_o;
    logic                  frame_o;
    logic [FRAME_BITS-1:0] frame_cnt_o;

    modport master (
        input  mode_i, speed_i, pause_i,
        output hsync_o, vsync_o, de_o, r_o, g_o, b_o, frame_o, frame_cnt_o
    );

    modport slave (
        output mode_i, speed_i, pause_i,
        input  hsync_o, vsync_o, de_o, r_o, g_o, b_o, frame_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw sync, active and frame strobes.
module vga_timing
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hsync_c,
    output logic          vsync_c,
    output logic          active_c,
    output logic          line_end_c,
    output logic          frame_upd_c,
    output logic          frame_start_c
);
    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic frame_end_c;

    always_comb begin
        line_end_c    = (32'(h) == H_TOTAL - 1);
        frame_end_c   = (32'(v) == V_TOTAL - 1);
        hsync_c       = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
        vsync_c       = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
        active_c      = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        frame_upd_c   = line_end_c && (32'(v) == V_ACTIVE - 1);
        frame_start_c = (h == '0) && (v == '0);
    end

    // Raster position: h wraps every line, v advances on line end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (line_end_c) begin
            h <= '0;
            v <= frame_end_c ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: scroll, bars, checker and gradient with frame-synchronous controls.
// Optional build macro VGA_PATTERN_BORDER_EN forces a 1-pixel white border around the active area.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_NEG   = 1,
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned CHK_SHIFT  = 5
) (
    input logic               clk,
    input logic               rst_n,
    vga_pattern_gen_if.master vif
);
    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = count_width(H_TOTAL);
    localparam int unsigned VW      = count_width(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BPW     = count_width(BAR_W + 1);
    localparam logic        SYNC_IDLE = 1'(SYNC_NEG);

    logic [HW-1:0]         h;
    logic [VW-1:0]         v;
    logic                  hsync_c;
    logic                  vsync_c;
    logic                  active_c;
    logic                  line_end_c;
    logic                  frame_upd_c;
    logic                  frame_start_c;

    logic [FRAME_BITS-1:0] frame_cnt_q;
    mode_e                 mode_q;
    logic [2:0]            speed_q;
    logic [2:0]            bar_idx_q;
    logic [BPW-1:0]        bar_pix_q;

    logic [9:0]            scroll_off_c;
    logic [2:0]            stripe_c;
    logic                  chk_c;
    logic [COLOR_BITS-1:0] pix_r_c;
    logic [COLOR_BITS-1:0] pix_g_c;
    logic [COLOR_BITS-1:0] pix_b_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HW       (HW),       .VW   (VW)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .h             (h),
        .v             (v),
        .hsync_c       (hsync_c),
        .vsync_c       (vsync_c),
        .active_c      (active_c),
        .line_end_c    (line_end_c),
        .frame_upd_c   (frame_upd_c),
        .frame_start_c (frame_start_c)
    );

    // Controls only change after the last visible line so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            mode_q      <= MODE_SCROLL;
            speed_q     <= '0;
        end else if (frame_upd_c) begin
            if (!vif.pause_i) begin
                frame_cnt_q <= frame_cnt_q + FRAME_BITS'(1);
            end
            mode_q  <= mode_e'(vif.mode_i);
            speed_q <= vif.speed_i;
        end
    end

    // Bar index tracks h via a pixel sub-counter, saturating on the last bar.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx_q <= '0;
            bar_pix_q <= '0;
        end else if (line_end_c) begin
            bar_idx_q <= '0;
            bar_pix_q <= '0;
        end else if (32'(bar_pix_q) == BAR_W - 1) begin
            bar_pix_q <= '0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_q <= bar_idx_q + 3'd1;
            end
        end else begin
            bar_pix_q <= bar_pix_q + BPW'(1);
        end
    end

    assign scroll_off_c = 10'(32'(frame_cnt_q) * 32'(speed_q));
    assign stripe_c     = 3'((10'(h) - scroll_off_c) >> 5);
    assign chk_c        = 1'(32'(h) >> CHK_SHIFT) ^ 1'(32'(v) >> CHK_SHIFT);

    always_comb begin
        pix_r_c = '0;
        pix_g_c = '0;
        pix_b_c = '0;
        if (active_c) begin
            case (mode_q)
                MODE_SCROLL: begin
                    pix_r_c = {COLOR_BITS{stripe_c[0]}};
                    pix_g_c = {COLOR_BITS{stripe_c[1]}};
                    pix_b_c = {COLOR_BITS{stripe_c[2]}};
                end
                MODE_BARS: begin
                    pix_r_c = {COLOR_BITS{bar_idx_q[0]}};
                    pix_g_c = {COLOR_BITS{bar_idx_q[1]}};
                    pix_b_c = {COLOR_BITS{bar_idx_q[2]}};
                end
                MODE_CHECK: begin
                    pix_r_c = {COLOR_BITS{chk_c}};
                    pix_g_c = {COLOR_BITS{chk_c}};
                    pix_b_c = {COLOR_BITS{chk_c}};
                end
                MODE_GRAD: begin
                    pix_r_c = COLOR_BITS'(32'(h) >> (8 - COLOR_BITS));
                    pix_g_c = COLOR_BITS'(32'(v) >> (8 - COLOR_BITS));
                    pix_b_c = COLOR_BITS'(32'(frame_cnt_q) >> (8 - COLOR_BITS));
                end
                default: ;
            endcase
`ifdef VGA_PATTERN_BORDER_EN
            if ((h == '0) || (32'(h) == H_ACTIVE - 1) || (v == '0) || (32'(v) == V_ACTIVE - 1)) begin
                pix_r_c = '1;
                pix_g_c = '1;
                pix_b_c = '1;
            end
`else
`endif
        end
    end

    // Single output register stage keeps sync, de, rgb and frame_o aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vif.hsync_o <= SYNC_IDLE;
            vif.vsync_o <= SYNC_IDLE;
            vif.de_o    <= 1'b0;
            vif.r_o     <= '0;
            vif.g_o     <= '0;
            vif.b_o     <= '0;
            vif.frame_o <= 1'b0;
        end else begin
            vif.hsync_o <= hsync_c ^ SYNC_IDLE;
            vif.vsync_o <= vsync_c ^ SYNC_IDLE;
            vif.de_o    <= active_c;
            vif.r_o     <= pix_r_c;
            vif.g_o     <= pix_g_c;
            vif.b_o     <= pix_b_c;
            vif.frame_o <= frame_start_c;
        end
    end

    assign vif.frame_cnt_o = frame_cnt_q;

endmodule
